// File: rtl/patt_tx_if.sv
// patt_tx_if: request/serial-line bundle for the patt_tx frame transmitter.
//   start  : frame request, sampled on posedge
//   data   : word to send, sampled only on the accepting edge
//   ready  : transmitter idle; a start seen while high is accepted
//   o      : registered serial line, 0 when idle
//   frame  : high while a preamble, data or parity bit is on o
//   done   : one-cycle pulse in the cycle after the parity bit
// Modports: master drives the request side, slave is the transmitter.
interface patt_tx_if #(
   parameter int unsigned DW = 8
) ();
   logic          start;
   logic [DW-1:0] data;
   logic          ready;
   logic          o;
   logic          frame;
   logic          done;

   modport master (
      output start,
      output data,
      input  ready,
      input  o,
      input  frame,
      input  done
   );

   modport slave (
      input  start,
      input  data,
      output ready,
      output o,
      output frame,
      output done
   );
endinterface

// File: rtl/patt_tx.sv
// patt_tx: serial frame transmitter. On an accepted start it sends, MSB first and one bit per
// clock, the PLEN-bit preamble PATTERN, the DW-bit data word and an even-parity bit. The line
// is held at 0 between frames.
// Ports:
//   clk   : single clock, posedge
//   rst_b : asynchronous active-low reset
//   bus   : patt_tx_if slave (start, data in; ready, o, frame, done out)
module patt_tx #(
   parameter int unsigned         PLEN    = 4,
   parameter logic [PLEN-1:0]     PATTERN = 4'b1011,
   parameter int unsigned         DW      = 8
) (
   input  logic     clk,
   input  logic     rst_b,
   patt_tx_if.slave bus
);
   localparam int unsigned MaxLen = (PLEN > DW) ? PLEN : DW;
   localparam int unsigned CW     = $clog2(MaxLen) + 1;

   typedef enum logic [1:0] {StIdle, StPre, StData, StPar} state_e;

   state_e          state_q, state_d;
   logic [PLEN-1:0] pre_q, pre_d;
   logic [DW-1:0]   data_q, data_d;
   logic            par_q, par_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            o_q, o_d;
   logic            frame_q, frame_d;
   logic            done_q, done_d;
   logic            ready_q, ready_d;

   // The state names the segment whose bit is currently on o; o_q is loaded with the bit
   // for the next cycle on the same edge that moves the state.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      data_d  = data_q;
      par_d   = par_q;
      cnt_d   = cnt_q;
      o_d     = 1'b0;
      frame_d = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               // First preamble bit goes straight to o; the rest stays queued in pre_q.
               o_d     = PATTERN[PLEN-1];
               pre_d   = PATTERN << 1;
               data_d  = bus.data;
               par_d   = ^bus.data;
               cnt_d   = CW'(PLEN - 1);
               frame_d = 1'b1;
               state_d = StPre;
            end
         end
         StPre: begin
            frame_d = 1'b1;
            if (cnt_q == '0) begin
               o_d     = data_q[DW-1];
               data_d  = data_q << 1;
               cnt_d   = CW'(DW - 1);
               state_d = StData;
            end else begin
               o_d   = pre_q[PLEN-1];
               pre_d = pre_q << 1;
               cnt_d = cnt_q - 1'b1;
            end
         end
         StData: begin
            frame_d = 1'b1;
            if (cnt_q == '0) begin
               o_d     = par_q;
               state_d = StPar;
            end else begin
               o_d    = data_q[DW-1];
               data_d = data_q << 1;
               cnt_d  = cnt_q - 1'b1;
            end
         end
         StPar: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= StIdle;
         pre_q   <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         cnt_q   <= '0;
         o_q     <= 1'b0;
         frame_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         data_q  <= data_d;
         par_q   <= par_d;
         cnt_q   <= cnt_d;
         o_q     <= o_d;
         frame_q <= frame_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign bus.o     = o_q;
   assign bus.frame = frame_q;
   assign bus.done  = done_q;
   assign bus.ready = ready_q;
endmodule

// File: tb/tb_patt_tx.sv
// tb_patt_tx: bench for patt_tx. A queue-based frame model is compared against the DUT on every
// clock; directed frames are also pinned against hand-computed bit strings.
module tb_patt_tx;
   localparam int unsigned     PLEN    = 4;
   localparam int unsigned     DW      = 8;
   localparam int unsigned     FLEN    = PLEN + DW + 1;
   localparam logic [PLEN-1:0] PATTERN = 4'b1011;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;
   logic cmp_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   patt_tx_if #(.DW(DW)) bus_if ();

   patt_tx #(
      .PLEN    (PLEN),
      .PATTERN (PATTERN),
      .DW      (DW)
   ) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: an accepted request enqueues the whole frame; one bit leaves per clock,
   // and the cycle after the last bit is the done cycle.
   bit   exp_q[$];
   logic m_o = 1'b0, m_frame = 1'b0, m_done = 1'b0, m_ready = 1'b1;

   function automatic void build(input logic [DW-1:0] d);
      for (int k = PLEN - 1; k >= 0; k--) exp_q.push_back(PATTERN[k]);
      for (int j = DW - 1; j >= 0; j--) exp_q.push_back(d[j]);
      exp_q.push_back(($countones(d) % 2) == 1);
   endfunction

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         exp_q.delete();
         m_o = 1'b0; m_frame = 1'b0; m_done = 1'b0; m_ready = 1'b1;
      end else if (m_ready && bus_if.start) begin
         build(bus_if.data);
         m_o = exp_q.pop_front(); m_frame = 1'b1; m_done = 1'b0; m_ready = 1'b0;
      end else if (exp_q.size() > 0) begin
         m_o = exp_q.pop_front(); m_frame = 1'b1; m_done = 1'b0; m_ready = 1'b0;
      end else if (m_frame) begin
         m_o = 1'b0; m_frame = 1'b0; m_done = 1'b1; m_ready = 1'b1;
      end else begin
         m_o = 1'b0; m_frame = 1'b0; m_done = 1'b0; m_ready = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (rst_b && cmp_en) begin
         chk("cyc_o", 64'(bus_if.o), 64'(m_o));
         chk("cyc_frame", 64'(bus_if.frame), 64'(m_frame));
         chk("cyc_done", 64'(bus_if.done), 64'(m_done));
         chk("cyc_ready", 64'(bus_if.ready), 64'(m_ready));
      end
   end

   // 1011 detector on the line, registered output.
   logic [3:0] hist;
   logic       det;
   int         det_cnt = 0;
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         hist <= '0;
         det  <= 1'b0;
      end else begin
         hist <= {hist[2:0], bus_if.o};
         det  <= ({hist[2:0], bus_if.o} == 4'b1011);
      end
   end
   always @(negedge clk) if (det) det_cnt++;

   // Requests one frame and records its FLEN line bits, starting the cycle after acceptance.
   task automatic send(input logic [DW-1:0] d, output logic [FLEN-1:0] bits, output int fr);
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.data  = d;
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.data  = ~d;
      bits = '0;
      fr   = 0;
      for (int i = 0; i < int'(FLEN); i++) begin
         bits = {bits[FLEN-2:0], bus_if.o};
         if (bus_if.frame) fr++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [FLEN-1:0] bits;
      logic [2*FLEN:0] b2b;
      int              fr;

      bus_if.start = 1'b0;
      bus_if.data  = '0;
      repeat (2) @(negedge clk);
      rst_b  = 1'b1;
      cmp_en = 1'b1;
      chk("rst_o", 64'(bus_if.o), 64'd0);
      chk("rst_frame", 64'(bus_if.frame), 64'd0);
      chk("rst_done", 64'(bus_if.done), 64'd0);
      chk("rst_ready", 64'(bus_if.ready), 64'd1);

      // Basic frame.
      send(8'hA5, bits, fr);
      chk("basic_bits", 64'(bits), 64'(13'b1011_10100101_0));
      chk("basic_frame_len", 64'(fr), 64'd13);
      chk("basic_done", 64'(bus_if.done), 64'd1);
      chk("basic_done_o", 64'(bus_if.o), 64'd0);
      @(negedge clk);
      chk("basic_done_once", 64'(bus_if.done), 64'd0);

      // Parity, then loopback on two zero frames.
      send(8'h01, bits, fr);
      chk("par_odd_bits", 64'(bits), 64'(13'b1011_00000001_1));
      det_cnt = 0;
      send(8'h00, bits, fr);
      chk("par_zero_bits", 64'(bits), 64'(13'b1011_00000000_0));
      send(8'h00, bits, fr);
      repeat (3) @(negedge clk);
      chk("loop_hits", 64'(det_cnt), 64'd2);

      // Busy start during the DATA phase.
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.data  = 8'hA5;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (5) @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.data  = 8'hFF;
      chk("busy_ready", 64'(bus_if.ready), 64'd0);
      repeat (4) @(negedge clk);
      bus_if.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy_done", 64'(bus_if.done), 64'd1);
      chk("busy_done_ready", 64'(bus_if.ready), 64'd1);
      fr = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus_if.frame) fr++;
      end
      chk("busy_no_second", 64'(fr), 64'd0);

      // Back-to-back with start held high.
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.data  = 8'hA5;
      @(negedge clk);
      bus_if.data  = 8'h5A;
      b2b = '0;
      for (int i = 0; i < int'(2 * FLEN + 1); i++) begin
         b2b = {b2b[2*FLEN-1:0], bus_if.o};
         @(negedge clk);
      end
      bus_if.start = 1'b0;
      chk("b2b_bits", 64'(b2b), 64'({13'b1011_10100101_0, 1'b0, 13'b1011_01011010_0}));
      repeat (16) @(negedge clk);

      // Mid-frame reset during the third preamble bit.
      bus_if.start = 1'b1;
      bus_if.data  = 8'hC3;
      @(negedge clk);
      bus_if.start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_b = 1'b0;
      #1;
      chk("mrst_o", 64'(bus_if.o), 64'd0);
      chk("mrst_frame", 64'(bus_if.frame), 64'd0);
      chk("mrst_ready", 64'(bus_if.ready), 64'd1);
      @(negedge clk);
      rst_b = 1'b1;
      send(8'h3C, bits, fr);
      chk("mrst_new_bits", 64'(bits), 64'(13'b1011_00111100_0));
      chk("mrst_new_frame_len", 64'(fr), 64'd13);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
